// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared state encoding for the serial-in parallel-out framer
package sipo_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      FULL  = ST_FULL
   } sipo_state_t;

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - frame bit index counter, 0..W-1, flags the last bit
module bit_counter #(
   parameter int W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic last
);

   localparam int CW = $clog2(W);

   logic [CW-1:0] cnt;

   assign last = (cnt == CW'(W - 1));

   // A clear with a same-cycle bit makes that bit index 0, so the count resumes at 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= inc ? CW'(1) : '0;
      end else if (inc) begin
         cnt <= last ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/sipo_framer.sv
// rtl/sipo_framer.sv - collects a W-bit serial frame into a registered parallel word
module sipo_framer #(
   parameter int W         = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sin,
   input  logic         sin_en,
   output logic [W-1:0] q,
   output logic         q_valid,
   input  logic         q_ready,
   output logic         overrun
);

   import sipo_pkg::*;

   sipo_state_t  state;
   logic [W-1:0] sr;
   logic [W-1:0] first;
   logic         last;
   logic         clr;
   logic         inc;

   function automatic logic [W-1:0] ins(input logic [W-1:0] v, input logic b);
      if (MSB_FIRST) return {v[W-2:0], b};
      else           return {b, v[W-1:1]};
   endfunction

   // A start is honoured everywhere except in FULL without a transfer, where it is dropped.
   assign clr   = start && ((state != FULL) || q_ready);
   assign inc   = sin_en && ((state == SHIFT) || clr);
   assign first = sin_en ? ins({W{1'b0}}, sin) : {W{1'b0}};

   bit_counter #(.W(W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (inc),
      .last (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         sr      <= '0;
         q       <= '0;
         q_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SHIFT;
                  sr    <= first;
               end
            end
            SHIFT: begin
               if (start) begin
                  sr <= first;
               end else if (sin_en) begin
                  sr <= ins(sr, sin);
                  if (last) begin
                     q       <= ins(sr, sin);
                     q_valid <= 1'b1;
                     state   <= FULL;
                  end
               end
            end
            FULL: begin
               if (q_ready) begin
                  q_valid <= 1'b0;
                  if (start) begin
                     state <= SHIFT;
                     sr    <= first;
                  end else begin
                     state <= IDLE;
                  end
               end else if (start || sin_en) begin
                  overrun <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
